// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with a scan-code set 2 decoder that tracks held
// W/A/S/D and arrow keys as registered levels, plus the raw byte stream.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] wasd,
  output logic [3:0] arrows,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic          r_clkMeta, r_clkSync, r_clkPrev;
  logic          r_datMeta, r_datSync;
  logic [3:0]    r_bitCnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_timeout;
  logic [7:0]    r_code;
  logic          r_codeValid, r_frameErr;
  logic [3:0]    r_wasd, r_arrows;
  state_t        r_state, w_stateNext;
  logic [3:0]    w_wasdNext, w_arrowsNext;
  logic          w_fall, w_frameDone, w_frameOk, w_frameBad, w_timeoutHit;
  logic [7:0]    w_byte;

  function automatic logic [3:0] baseMask(input logic [7:0] b);
    case (b)
      8'h1D:   baseMask = 4'b0001;
      8'h1C:   baseMask = 4'b0010;
      8'h1B:   baseMask = 4'b0100;
      8'h23:   baseMask = 4'b1000;
      default: baseMask = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] extMask(input logic [7:0] b);
    case (b)
      8'h75:   extMask = 4'b0001;
      8'h6B:   extMask = 4'b0010;
      8'h72:   extMask = 4'b0100;
      8'h74:   extMask = 4'b1000;
      default: extMask = 4'b0000;
    endcase
  endfunction

  // Bits arrive LSB first and enter at the top, so after ten shifts
  // r_shift[0] holds the start bit and r_shift[9] the parity bit.
  assign w_fall       = r_clkPrev & ~r_clkSync;
  assign w_frameDone  = w_fall && (r_bitCnt == 4'd10);
  assign w_byte       = r_shift[8:1];
  assign w_frameOk    = w_frameDone && !r_shift[0] && r_datSync && (^r_shift[9:1]);
  assign w_frameBad   = w_frameDone && !w_frameOk;
  assign w_timeoutHit = (r_bitCnt != 4'd0) && (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_clkMeta   <= 1'b1;
      r_clkSync   <= 1'b1;
      r_clkPrev   <= 1'b1;
      r_datMeta   <= 1'b1;
      r_datSync   <= 1'b1;
      r_bitCnt    <= 4'd0;
      r_shift     <= 10'd0;
      r_timeout   <= '0;
      r_code      <= 8'h00;
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_clkMeta   <= PS2_CLK;
      r_clkSync   <= r_clkMeta;
      r_clkPrev   <= r_clkSync;
      r_datMeta   <= PS2_DAT;
      r_datSync   <= r_datMeta;
      r_codeValid <= w_frameOk;
      r_frameErr  <= w_frameBad;
      if (w_frameOk) begin
        r_code <= w_byte;
      end
      if (w_fall) begin
        r_timeout <= '0;
        if (r_bitCnt == 4'd10) begin
          r_bitCnt <= 4'd0;
        end else begin
          r_bitCnt <= r_bitCnt + 4'd1;
          r_shift  <= {r_datSync, r_shift[9:1]};
        end
      end else if (w_timeoutHit) begin
        r_bitCnt  <= 4'd0;
        r_timeout <= '0;
      end else if (r_bitCnt != 4'd0) begin
        r_timeout <= r_timeout + 1'b1;
      end else begin
        r_timeout <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_wasd   <= 4'b0000;
      r_arrows <= 4'b0000;
    end else begin
      r_state  <= w_stateNext;
      r_wasd   <= w_wasdNext;
      r_arrows <= w_arrowsNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_frameBad) begin
      w_stateNext = IDLE;
    end else if (w_frameOk) begin
      case (r_state)
        IDLE: begin
          if (w_byte == 8'hE0)      w_stateNext = EXT;
          else if (w_byte == 8'hF0) w_stateNext = BRK;
          else                      w_stateNext = IDLE;
        end
        EXT: begin
          if (w_byte == 8'hF0) w_stateNext = EXT_BRK;
          else                 w_stateNext = IDLE;
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Held-key levels are updated in the same cycle the byte is accepted.
  always_comb begin
    w_wasdNext   = r_wasd;
    w_arrowsNext = r_arrows;
    if (w_frameOk) begin
      case (r_state)
        IDLE: begin
          if (w_byte != 8'hE0 && w_byte != 8'hF0) w_wasdNext = r_wasd | baseMask(w_byte);
        end
        EXT: begin
          if (w_byte != 8'hF0) w_arrowsNext = r_arrows | extMask(w_byte);
        end
        BRK:     w_wasdNext   = r_wasd & ~baseMask(w_byte);
        EXT_BRK: w_arrowsNext = r_arrows & ~extMask(w_byte);
        default: w_wasdNext   = r_wasd;
      endcase
    end
  end

  assign wasd       = r_wasd;
  assign arrows     = r_arrows;
  assign code       = r_code;
  assign code_valid = r_codeValid;
  assign frame_err  = r_frameErr;

endmodule
